instr_decode_stage: RTL and testbench

//  Registered, flow-controlled successor to the combinational instruction field parser.

---
 rtl/instr_decode_stage.sv | 186 ++++++++++++++++++
 tb/tb_instr_decode_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Registered, flow-controlled LEGv8 instruction decode stage. Classifies each
//   fetched instruction (R/D/I/B/CB/IW/UNK), extracts register numbers, shift
//   amount and an extended immediate, and presents the result one cycle after
//   acceptance through a 2-entry skid buffer (main entry drives out_*, skid
//   entry absorbs one extra word while the output is stalled).
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             drop both buffered entries and any word offered this cycle
//   in_valid/in_ready upstream handshake (in_ready is registered)
//   in_instr, in_pc   instruction word and its PC
//   out_valid/out_ready downstream handshake
//   out_*             decoded fields of the main entry
//   illegal_count     saturating count of delivered UNK entries
module instr_decode_stage #(
  parameter int unsigned INSTR_LEN  = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PC_WIDTH   = 64,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_LEN-1:0]  in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [10:0]           out_opcode,
  output logic [2:0]            out_fmt,
  output logic [4:0]            out_rm_num,
  output logic [4:0]            out_rn_num,
  output logic [4:0]            out_rd_num,
  output logic [4:0]            out_rs2_num,
  output logic [5:0]            out_shamt,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  illegal_count
);

  localparam logic [2:0] FmtR   = 3'd0;
  localparam logic [2:0] FmtD   = 3'd1;
  localparam logic [2:0] FmtI   = 3'd2;
  localparam logic [2:0] FmtB   = 3'd3;
  localparam logic [2:0] FmtCb  = 3'd4;
  localparam logic [2:0] FmtIw  = 3'd5;
  localparam logic [2:0] FmtUnk = 3'd7;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [10:0]           opcode;
    logic [2:0]            fmt;
    logic [4:0]            rm;
    logic [4:0]            rn;
    logic [4:0]            rd;
    logic [4:0]            rs2;
    logic [5:0]            shamt;
    logic [DATA_WIDTH-1:0] imm;
    logic                  illegal;
  } entry_t;

  entry_t dec;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [10:0] opc;
  logic        accept;
  logic        drain;

  // Combinational decode of the offered word
  always_comb begin
    opc = in_instr[31:21];
    dec = '0;
    dec.pc     = in_pc;
    dec.opcode = opc;
    dec.rm     = in_instr[20:16];
    dec.rn     = in_instr[9:5];
    dec.rd     = in_instr[4:0];

    if (opc == 11'd1112 || opc == 11'd1624 || opc == 11'd1104 ||
        opc == 11'd1360 || opc == 11'd1691 || opc == 11'd1690) begin
      dec.fmt = FmtR;
    end else if (opc == 11'd1986 || opc == 11'd1984) begin
      dec.fmt = FmtD;
    end else if (opc[10:1] == 10'b1001000100 || opc[10:1] == 10'b1101000100) begin
      dec.fmt = FmtI;
    end else if (opc[10:5] == 6'b000101) begin
      dec.fmt = FmtB;
    end else if (opc[10:3] == 8'b10110100 || opc[10:3] == 8'b10110101) begin
      dec.fmt = FmtCb;
    end else if (opc[10:2] == 9'b110100101) begin
      dec.fmt = FmtIw;
    end else begin
      dec.fmt = FmtUnk;
    end

    // Store and compare-branch read their second operand from the Rt field
    dec.rs2 = (dec.fmt == FmtD || dec.fmt == FmtCb) ? in_instr[4:0] : in_instr[20:16];
    dec.shamt   = (dec.fmt == FmtR) ? in_instr[15:10] : 6'd0;
    dec.illegal = (dec.fmt == FmtUnk);

    case (dec.fmt)
      FmtD:    dec.imm = DATA_WIDTH'($signed(in_instr[20:12]));
      FmtI:    dec.imm = DATA_WIDTH'(in_instr[21:10]);
      FmtB:    dec.imm = DATA_WIDTH'($signed(in_instr[25:0]));
      FmtCb:   dec.imm = DATA_WIDTH'($signed(in_instr[23:5]));
      FmtIw:   dec.imm = DATA_WIDTH'(in_instr[20:5]) << {in_instr[22:21], 4'b0000};
      default: dec.imm = '0;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign drain  = main_valid_q & out_ready;

  // Buffer next state. in_ready is low whenever the skid entry holds data,
  // so an accept and a skid-to-main move never coincide.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (drain && main_q.illegal && cnt_q != {CNT_WIDTH{1'b1}}) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready      = ~skid_valid_q;
  assign out_valid     = main_valid_q;
  assign out_pc        = main_q.pc;
  assign out_opcode    = main_q.opcode;
  assign out_fmt       = main_q.fmt;
  assign out_rm_num    = main_q.rm;
  assign out_rn_num    = main_q.rn;
  assign out_rd_num    = main_q.rd;
  assign out_rs2_num   = main_q.rs2;
  assign out_shamt     = main_q.shamt;
  assign out_imm       = main_q.imm;
  assign out_illegal   = main_q.illegal;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [10:0] opcode;
    logic [2:0]  fmt;
    logic [4:0]  rm;
    logic [4:0]  rn;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [5:0]  shamt;
    logic [63:0] imm;
    logic        illegal;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [10:0] out_opcode;
  logic [2:0]  out_fmt;
  logic [4:0]  out_rm_num, out_rn_num, out_rd_num, out_rs2_num;
  logic [5:0]  out_shamt;
  logic [63:0] out_imm;
  logic        out_illegal;
  logic [15:0] illegal_count;

  dec_t obs;
  dec_t exp_e;
  dec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] vec_instr [11];
  dec_t        vec_exp   [11];

  always #5 clk = ~clk;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_fmt(out_fmt), .out_rm_num(out_rm_num),
    .out_rn_num(out_rn_num), .out_rd_num(out_rd_num), .out_rs2_num(out_rs2_num),
    .out_shamt(out_shamt), .out_imm(out_imm), .out_illegal(out_illegal),
    .illegal_count(illegal_count)
  );

  assign obs = {out_pc, out_opcode, out_fmt, out_rm_num, out_rn_num, out_rd_num,
                out_rs2_num, out_shamt, out_imm, out_illegal};

  function automatic dec_t mk(input logic [10:0] op, input logic [2:0] fmt,
                              input logic [4:0] rm, input logic [4:0] rn,
                              input logic [4:0] rd, input logic [4:0] rs2,
                              input logic [5:0] sh, input logic [63:0] imm);
    dec_t d;
    d = '{pc: 64'd0, opcode: op, fmt: fmt, rm: rm, rn: rn, rd: rd, rs2: rs2,
          shamt: sh, imm: imm, illegal: (fmt == 3'd7)};
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer vector idx; if the DUT takes it this edge, queue its expected decode
  task automatic offer(input int idx, input logic [63:0] pc);
    dec_t e;
    in_valid = 1'b1;
    in_instr = vec_instr[idx];
    in_pc    = pc;
    e        = vec_exp[idx];
    e.pc     = pc;
    if (in_ready && !flush && !rst) sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (illegal_count !== 16'd0) begin n_bad++;
      $display("FAIL reset_count: got %0d want 0", illegal_count); end
    n_cmp++; if (obs !== '0) begin n_bad++;
      $display("FAIL reset_fields: got %h want 0", obs); end
  endtask

  // One word at a time: visible right after its accept edge, gone after drain
  task automatic test_decode();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(i, 64'h1000 + 64'(4 * i));
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++;
        $display("FAIL decode_latency[%0d]: got out_valid %b want 1", i, out_valid); end
      exp_e = sb.pop_front();
      n_cmp++; if (obs !== exp_e) begin n_bad++;
        $display("FAIL decode[%0d]: got %h want %h", i, obs, exp_e); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
        $display("FAIL decode_drained[%0d]: got out_valid %b want 0", i, out_valid); end
    end
  endtask

  // Accept and drain every cycle: main replaced, skid never used
  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(i + 2, 64'h2000 + 64'(4 * i));
      tick();
      n_cmp++; if (obs !== sb[0] || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_bad++;
        $display("FAIL stream[%0d]: got %h v%b r%b want %h v1 r1", i, obs, out_valid,
                 in_ready, sb[0]); end
      void'(sb.pop_front());
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer(i, 64'h3000 + 64'(4 * i));
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (sb.size() != 2) begin n_bad++;
      $display("FAIL b2b_accepted: got %0d want 2", sb.size()); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== sb[0]) begin n_bad++;
        $display("FAIL b2b_stall[%0d]: got %h r%b v%b want %h r0 v1", i, obs, in_ready,
                 out_valid, sb[0]); end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || obs !== sb[0]) begin n_bad++;
        $display("FAIL b2b_order[%0d]: got %h v%b want %h", i, obs, out_valid, sb[0]); end
      void'(sb.pop_front());
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++;
        $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL b2b_empty: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    offer(0, 64'h4000); tick();
    offer(1, 64'h4004); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++;
      $display("FAIL flush_full: got in_ready %b want 0", in_ready); end
    flush = 1'b1;
    offer(2, 64'h4008);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
      $display("FAIL flush_cleared: got v%b r%b want v0 r1", out_valid, in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
        $display("FAIL flush_ghost[%0d]: got out_valid %b pc %h want 0", i, out_valid,
                 out_pc); end
    end
    // Flush beats an acceptable offer
    flush = 1'b1;
    offer(3, 64'h400C);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_wins: got out_valid %b want 0", out_valid); end
    offer(4, 64'h4010);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || obs !== sb[0]) begin n_bad++;
      $display("FAIL flush_resume: got %h v%b want %h", obs, out_valid, sb[0]); end
    void'(sb.pop_front());
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(10, 64'h5000 + 64'(4 * i));
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || obs !== sb[0]) begin
        n_bad++;
        $display("FAIL illegal[%0d]: got %h v%b want %h", i, obs, out_valid, sb[0]); end
      void'(sb.pop_front());
      tick();
    end
    n_cmp++; if (illegal_count !== 16'd3) begin n_bad++;
      $display("FAIL illegal_count: got %0d want 3", illegal_count); end
    // Reset with both entries occupied and a word on offer
    out_ready = 1'b0;
    offer(0, 64'h5100); tick();
    offer(1, 64'h5104); tick();
    rst = 1'b1;
    in_instr = vec_instr[2];
    tick();
    rst = 1'b0; in_valid = 1'b0;
    sb.delete();
    n_cmp++; if (illegal_count !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
                 obs !== '0) begin n_bad++;
      $display("FAIL midreset: got cnt %0d v%b r%b %h want 0 0 1 0", illegal_count,
               out_valid, in_ready, obs); end
    out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++;
      $display("FAIL midreset_ghost: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_random();
    int exp_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      out_ready = 1'($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) offer($urandom_range(0, 10), 64'($urandom));
      else in_valid = 1'b0;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++;
          $display("FAIL rand_extra[%0d]: got %h want none", c, obs);
        end else begin
          exp_e = sb.pop_front();
          if (exp_e.illegal) exp_cnt++;
          if (obs !== exp_e) begin n_bad++;
            $display("FAIL rand[%0d]: got %h want %h", c, obs, exp_e); end
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (out_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin n_bad++;
          $display("FAIL rand_extra_drain: got %h want none", obs);
        end else begin
          exp_e = sb.pop_front();
          if (exp_e.illegal) exp_cnt++;
          if (obs !== exp_e) begin n_bad++;
            $display("FAIL rand_drain: got %h want %h", obs, exp_e); end
        end
      end
      tick();
    end
    n_cmp++; if (sb.size() != 0) begin n_bad++;
      $display("FAIL rand_lost: got %0d left want 0", sb.size()); end
    n_cmp++; if (illegal_count !== 16'(exp_cnt)) begin n_bad++;
      $display("FAIL rand_count: got %0d want %0d", illegal_count, exp_cnt); end
  endtask

  initial begin
    vec_instr[0]  = 32'hF84F02C9; vec_exp[0]  = mk(11'd1986, 3'd1, 5'd15, 5'd22, 5'd9, 5'd9, 6'd0, 64'd240);
    vec_instr[1]  = 32'h8B0902AA; vec_exp[1]  = mk(11'd1112, 3'd0, 5'd9, 5'd21, 5'd10, 5'd9, 6'd0, 64'd0);
    vec_instr[2]  = 32'hF80402EA; vec_exp[2]  = mk(11'd1984, 3'd1, 5'd4, 5'd23, 5'd10, 5'd10, 6'd0, 64'd64);
    vec_instr[3]  = 32'hF85F8041; vec_exp[3]  = mk(11'd1986, 3'd1, 5'd31, 5'd2, 5'd1, 5'd1, 6'd0,
                                                   64'hFFFF_FFFF_FFFF_FFF8);
    vec_instr[4]  = 32'h14000001; vec_exp[4]  = mk(11'd160, 3'd3, 5'd0, 5'd0, 5'd1, 5'd0, 6'd0, 64'd1);
    vec_instr[5]  = 32'h913FFC41; vec_exp[5]  = mk(11'd1161, 3'd2, 5'd31, 5'd2, 5'd1, 5'd31, 6'd0, 64'd4095);
    vec_instr[6]  = 32'hB4FFFFC3; vec_exp[6]  = mk(11'd1447, 3'd4, 5'd31, 5'd30, 5'd3, 5'd3, 6'd0,
                                                   64'hFFFF_FFFF_FFFF_FFFE);
    vec_instr[7]  = 32'hD2C24685; vec_exp[7]  = mk(11'd1686, 3'd5, 5'd2, 5'd20, 5'd5, 5'd2, 6'd0,
                                                   64'h0000_1234_0000_0000);
    vec_instr[8]  = 32'hD3600C41; vec_exp[8]  = mk(11'd1691, 3'd0, 5'd0, 5'd2, 5'd1, 5'd0, 6'd3, 64'd0);
    vec_instr[9]  = 32'h17FFFFFF; vec_exp[9]  = mk(11'd191, 3'd3, 5'd31, 5'd31, 5'd31, 5'd31, 6'd0,
                                                   64'hFFFF_FFFF_FFFF_FFFF);
    vec_instr[10] = 32'h00000000; vec_exp[10] = mk(11'd0, 3'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 64'd0);

    test_reset();
    test_decode();
    test_stream();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
